// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master modport is the loader side; the slave modport is the byte
// source / memory side.
interface program_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and
// writes them into instruction memory, holding the CPU in reset meanwhile.
// A load is started with a word count, can be aborted, and finishes in DONE
// or ERROR, where the status outputs hold until the next accepted start.
module program_loader #(
  parameter int DEPTH = 101,
  parameter int LW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] length,
  input  logic          abort,
  program_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [1:0]    cnt;
  logic [31:0]   shreg;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   wr_addr;
  logic          xfer;
  logic          last_word;

  // A byte is taken only in LOAD and only when no abort is pending; an abort
  // in the same cycle discards the byte.
  assign xfer      = (state == S_LOAD) && bus.byte_valid && !abort;
  assign last_word = (idx == (len - LW'(1)));
  assign wr_addr   = {{(30-LW){1'b0}}, idx, 2'b00};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured when no load is in progress
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if (length == '0) begin
            state_nxt = S_DONE;
          end else if (length > DEPTH_L) begin
            state_nxt = S_ERROR;
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nxt = S_ERROR;
        end else if (xfer && (cnt == 2'd3)) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write itself always completes; abort only redirects the exit.
        if (abort) begin
          state_nxt = S_ERROR;
        end else if (last_word) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: length latch, word index, byte lane counter, shift register and
  // the held copies of the last memory address/data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len     <= '0;
      idx     <= '0;
      cnt     <= '0;
      shreg   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (state_nxt == S_LOAD) begin
            len <= length;
            idx <= '0;
            cnt <= '0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            shreg[{cnt, 3'b000} +: 8] <= bus.byte_data;
            cnt                       <= cnt + 2'd1;
          end
        end
        S_WRITE: begin
          addr_q  <= wr_addr;
          wdata_q <= shreg;
          if (state_nxt == S_LOAD) begin
            idx <= idx + LW'(1);
            cnt <= '0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state; address/data are live in WRITE and hold the
  // last written values everywhere else
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = wdata_q;
    cpu_hold       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      S_LOAD: begin
        bus.byte_ready = 1'b1;
        cpu_hold       = 1'b1;
        busy           = 1'b1;
      end
      S_WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wr_addr;
        bus.mem_wdata = shreg;
        cpu_hold      = 1'b1;
        busy          = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        bus.byte_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader.
module tb_program_loader;
  localparam int DEPTH = 101;
  localparam int LW    = 7;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          abort  = 1'b0;
  logic [LW-1:0] length = '0;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  program_loader_if bus_if ();

  program_loader #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .length   (length),
    .abort    (abort),
    .bus      (bus_if.master),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        in_load    = 1'b0;
  int          hold_drops = 0;

  // Record every memory write and watch cpu_hold while a load is running
  always @(negedge clk) begin
    if (bus_if.mem_we === 1'b1) begin
      wr_addr.push_back(bus_if.mem_addr);
      wr_data.push_back(bus_if.mem_wdata);
    end
    if (in_load && (cpu_hold !== 1'b1)) hold_drops++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wa(input int i);
    return (wr_addr.size() > i) ? wr_addr[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return (wr_data.size() > i) ? wr_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'h5A, ~b, 8'hA5, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic do_start(input logic [LW-1:0] len);
    start  = 1'b1;
    length = len;
    tick();
    start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    bus_if.byte_valid = 1'b1;
    bus_if.byte_data  = b;
    for (int i = 0; i < 20 && (bus_if.byte_ready !== 1'b1); i++) tick();
    if (bus_if.byte_ready !== 1'b1) begin
      check("ready_timeout", 32'd0, 32'd1);
      bus_if.byte_valid = 1'b0;
      return;
    end
    tick();
    bus_if.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic check_two_word_load(input string tag);
    check({tag, "_nwr"},   32'(wr_addr.size()), 32'd2);
    check({tag, "_a0"},    wa(0), 32'h0000_0000);
    check({tag, "_d0"},    wd(0), 32'hE3A0_0078);
    check({tag, "_a1"},    wa(1), 32'h0000_0004);
    check({tag, "_d1"},    wd(1), 32'hE3A0_2079);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_hold"},  32'(cpu_hold), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.byte_valid = 1'b0;
    bus_if.byte_data  = 8'h00;

    // Reset state
    #3;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_hold",  32'(cpu_hold), 32'd0);
    check("rst_ready", 32'(bus_if.byte_ready), 32'd0);
    check("rst_we",    32'(bus_if.mem_we), 32'd0);
    check("rst_addr",  bus_if.mem_addr, 32'd0);
    check("rst_wdata", bus_if.mem_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Two-word load, back-to-back bytes
    clear_log();
    do_start(7'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd1);
    check("t1_ready", 32'(bus_if.byte_ready), 32'd1);
    send_word(32'hE3A0_0078, 0);
    check("t1_we0",    32'(bus_if.mem_we), 32'd1);
    check("t1_addr0",  bus_if.mem_addr, 32'd0);
    check("t1_wdata0", bus_if.mem_wdata, 32'hE3A0_0078);
    check("t1_rdy_w",  32'(bus_if.byte_ready), 32'd0);
    send_word(32'hE3A0_2079, 0);
    check("t1_we1",    32'(bus_if.mem_we), 32'd1);
    tick();
    check_two_word_load("t1");
    check("t1_hold_addr",  bus_if.mem_addr, 32'd4);
    check("t1_hold_wdata", bus_if.mem_wdata, 32'hE3A0_2079);
    check("t1_we_off",     32'(bus_if.mem_we), 32'd0);

    // Same load with random byte_valid gaps
    clear_log();
    do_start(7'd2);
    hold_drops = 0;
    in_load    = 1'b1;
    send_word(32'hE3A0_0078, 5);
    send_word(32'hE3A0_2079, 5);
    in_load = 1'b0;
    tick();
    check_two_word_load("t2");
    check("t2_hold_drops", 32'(hold_drops), 32'd0);

    // Oversize length then zero length
    clear_log();
    do_start(7'd102);
    check("t3_err",   32'(error), 32'd1);
    check("t3_done",  32'(done), 32'd0);
    check("t3_hold",  32'(cpu_hold), 32'd0);
    check("t3_busy",  32'(busy), 32'd0);
    do_start(7'd0);
    check("t3z_done", 32'(done), 32'd1);
    check("t3z_err",  32'(error), 32'd0);
    check("t3z_hold", 32'(cpu_hold), 32'd0);
    tick();
    check("t3_nwr",   32'(wr_addr.size()), 32'd0);

    // Abort two bytes into word 1, with a byte presented alongside the abort
    clear_log();
    do_start(7'd3);
    send_word(32'h0403_0201, 0);
    send_byte(8'h05, 0);
    send_byte(8'h06, 0);
    abort             = 1'b1;
    bus_if.byte_valid = 1'b1;
    bus_if.byte_data  = 8'h07;
    tick();
    abort             = 1'b0;
    bus_if.byte_valid = 1'b0;
    check("t4_err",  32'(error), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_hold", 32'(cpu_hold), 32'd0);
    repeat (3) tick();
    check("t4_nwr",  32'(wr_addr.size()), 32'd1);
    check("t4_a0",   wa(0), 32'd0);
    check("t4_d0",   wd(0), 32'h0403_0201);

    // Abort coincident with WRITE: the write lands, then ERROR
    clear_log();
    do_start(7'd2);
    send_word(32'h4433_2211, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_err",  32'(error), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_we",   32'(bus_if.mem_we), 32'd0);
    tick();
    check("t5_nwr",  32'(wr_addr.size()), 32'd1);
    check("t5_d0",   wd(0), 32'h4433_2211);

    // Asynchronous reset in the middle of a load, then a one-word load
    clear_log();
    do_start(7'd2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_hold",  32'(cpu_hold), 32'd0);
    check("t6_ready", 32'(bus_if.byte_ready), 32'd0);
    check("t6_we",    32'(bus_if.mem_we), 32'd0);
    check("t6_err",   32'(error), 32'd0);
    check("t6_addr",  bus_if.mem_addr, 32'd0);
    check("t6_wdata", bus_if.mem_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_nwr",   32'(wr_addr.size()), 32'd0);
    do_start(7'd1);
    send_word(32'hEFBE_ADDE, 0);
    tick();
    check("t6_done",  32'(done), 32'd1);
    check("t6_nwr1",  32'(wr_addr.size()), 32'd1);
    check("t6_a0",    wa(0), 32'd0);
    check("t6_d0",    wd(0), 32'hEFBE_ADDE);

    // Full-depth load with a start pulse injected mid-load
    clear_log();
    do_start(7'(DEPTH));
    send_word(word_of(0), 0);
    send_byte(word_of(1)[7:0], 0);
    send_byte(word_of(1)[15:8], 0);
    do_start(7'd0);
    check("t7_busy",  32'(busy), 32'd1);
    check("t7_done",  32'(done), 32'd0);
    check("t7_err",   32'(error), 32'd0);
    send_byte(word_of(1)[23:16], 0);
    send_byte(word_of(1)[31:24], 0);
    for (int i = 2; i < DEPTH; i++) send_word(word_of(i), 0);
    check("t7_last_we", 32'(bus_if.mem_we), 32'd1);
    tick();
    check("t7_done_end", 32'(done), 32'd1);
    check("t7_hold_end", 32'(cpu_hold), 32'd0);
    check("t7_nwr",      32'(wr_addr.size()), 32'(DEPTH));
    check("t7_last_addr", wa(DEPTH - 1), 32'd400);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("t7_a%0d", i), wa(i), 32'(4 * i));
      check($sformatf("t7_d%0d", i), wd(i), word_of(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 101: number of 32-bit words in the writable instruction memory.
REQ-002 Parameter LW, default 7: width of the length and word-index fields; 2^LW SHALL be greater than DEPTH.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE and ERROR.
REQ-006 length  in  LW  number of words to load; latched on accepted start.
REQ-007 abort  in  1  cancels an active load.
REQ-008 byte_valid  in  1  byte_data holds a valid byte.
REQ-009 byte_data  in  8  program byte stream, little-endian per word.
REQ-010 byte_ready  out  1  loader can accept a byte; a byte transfers when byte_valid and byte_ready are both 1 on a clock edge.
REQ-011 mem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-012 mem_addr  out  32  byte address of the write, word-aligned (bits [1:0] = 0).
REQ-013 mem_wdata  out  32  assembled instruction word.
REQ-014 cpu_hold  out  1  holds the processor in reset while high.
REQ-015 busy  out  1  high in LOAD and WRITE.
REQ-016 done  out  1  high in DONE.
REQ-017 error  out  1  high in ERROR.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, WRITE, DONE and ERROR.
REQ-019 From IDLE, DONE or ERROR, a start with length = 0 SHALL go to DONE; a start with length > DEPTH SHALL go to ERROR; any other start SHALL go to LOAD and latch length, with the word index = 0 and the byte count = 0.
REQ-020 In LOAD, byte_ready SHALL be 1 and each transferred byte SHALL be written to shift-register lane [8*k+7:8*k], where k is the byte count (0..3); the byte count then increments.
REQ-021 The transfer with k = 3 SHALL move the FSM to WRITE on the next edge.
REQ-022 WRITE SHALL last exactly one cycle with mem_we = 1, mem_addr = index*4 and mem_wdata = the assembled word; byte_ready SHALL be 0.
REQ-023 Leaving WRITE: if index = length-1, the FSM SHALL go to DONE; otherwise index SHALL increment, byte count SHALL clear, and the FSM SHALL return to LOAD.
REQ-024 Latency: the mem_we cycle SHALL immediately follow the edge that accepts the 4th byte of a word.
REQ-025 cpu_hold SHALL be 1 in LOAD and WRITE, and 0 in IDLE, DONE and ERROR.
REQ-026 In LOAD, abort SHALL move the FSM to ERROR; a byte presented in the same cycle SHALL be discarded.
REQ-027 In WRITE, abort SHALL be deferred: the write completes, then the FSM goes to ERROR instead of LOAD or DONE.
REQ-028 start SHALL be ignored in LOAD and WRITE.
REQ-029 In DONE and ERROR, the outputs SHALL hold until the next accepted start.
REQ-030 mem_we SHALL never be asserted outside WRITE.
REQ-031 mem_addr and mem_wdata SHALL hold their last values outside WRITE.
REQ-032 Index arithmetic SHALL be LW-bit unsigned; mem_addr SHALL be the index zero-extended and shifted left by 2.

Reset
REQ-033 While rst_n = 0, the FSM SHALL be in IDLE, and index, byte count, shift register, mem_addr and mem_wdata SHALL be 0.
REQ-034 While rst_n = 0, all outputs (mem_we, byte_ready, cpu_hold, busy, done, error) SHALL be 0.
REQ-035 Reset asserted mid-load SHALL abandon the load immediately, with no further mem_we.

Verification
REQ-036 Send start with length = 2, then the bytes 78,00,A0,E3,79,20,A0,E3 back-to-back -> mem_we at addr 0 with data E3A00078, then at addr 4 with data E3A02079; then done = 1 and cpu_hold = 0.
REQ-037 Same load with byte_valid gaps of 0-5 random cycles -> identical writes; cpu_hold stays 1 throughout the load.
REQ-038 start with length = 0 -> DONE the next cycle with no mem_we; start with length = 102 -> ERROR with no mem_we and cpu_hold = 0.
REQ-039 abort after 2 bytes of word 1 -> ERROR with exactly one write (word 0); abort coincident with WRITE -> that write occurs, then ERROR.
REQ-040 rst_n pulsed low during LOAD -> all outputs go to 0 asynchronously; a subsequent start with length = 1 loads correctly at addr 0.
REQ-041 start asserted during LOAD -> no effect; full load at length = DEPTH -> last write at addr 400, then done = 1.
